transmitter_ash: RTL and testbench
==================================

TRANSMITTER_ASH -- requirements
Module: transmitter_ash

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (16x oversample rate); legal range 2..256.
REQ-002 SHALL have parameter PARITY_EN, default 1; 1 = parity bit sent, 0 = frame omits parity bit.
REQ-003 SHALL have parameter PARITY_ODD, default 0; 0 = even parity (XOR of data bits), 1 = odd parity (inverted XOR).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port TX_Data, input, 8, byte to send, sampled only on accept.
REQ-007 SHALL have port Valid_tx, input, 1, producer offers TX_Data.
REQ-008 SHALL have port Ready_tx, output, 1, holding register empty, byte can be accepted.
REQ-009 SHALL have port TXD, output, 1, serial line, idle high, registered.
REQ-010 SHALL have port Busy, output, 1, high whenever the FSM is not IDLE.
REQ-011 SHALL have port Done, output, 1, one-cycle pulse at end of each stop bit.

Function
REQ-012 SHALL accept a byte on any posedge where Valid_tx=1 and Ready_tx=1, copying TX_Data into a one-entry holding register and setting hold_full.
REQ-013 SHALL drive Ready_tx = !hold_full, combinationally from a register only; Valid_tx while Ready_tx=0 SHALL be ignored and TX_Data not sampled.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; any illegal encoding SHALL return to IDLE next cycle with TXD=1.
REQ-015 IDLE: TXD=1; if hold_full, next edge SHALL load the shift register from hold, clear hold_full, enter START.
REQ-016 START: TXD=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index 0..7; after bit 7 go to PARITY if PARITY_EN=1, else STOP.
REQ-018 Parity SHALL be computed from the loaded byte at load time (XOR of 8 bits, inverted if PARITY_ODD); PARITY state holds that value on TXD for CLKS_PER_BIT cycles, then STOP.
REQ-019 STOP: TXD=1 for CLKS_PER_BIT cycles; on the last cycle Done=1 for that one cycle.
REQ-020 At end of STOP, if hold_full, SHALL load and enter START directly (no idle cycle between frames); else enter IDLE.
REQ-021 A byte accepted during any state SHALL wait in hold without disturbing the frame in flight.
REQ-022 Latency: byte accepted at edge E0 with FSM IDLE -> TXD falls after edge E1; Ready_tx high again after E1.
REQ-023 Frame length SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles; bit counter width ceil(log2(CLKS_PER_BIT)), wrapping to 0 at CLKS_PER_BIT-1.
REQ-024 Busy SHALL be 1 from the first START cycle through the last STOP cycle and 0 in IDLE.

Reset
REQ-025 While reset=1 at a posedge: state=IDLE, TXD=1, hold_full=0 (Ready_tx=1), Busy=0, Done=0, counters and shift register=0.
REQ-026 Reset mid-frame SHALL abort the frame and discard any held byte; TXD=1 from the next edge, no Done pulse.
REQ-027 Reset has priority over an accept in the same cycle; that byte is dropped.

Verification
REQ-028 Defaults, send 0xA5 -> TXD = 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each 16 cycles; Done at cycle 176; Busy 176 cycles.
REQ-029 Send 0x07, PARITY_EN=1 even -> parity bit 1; with PARITY_ODD=1 -> parity 0.
REQ-030 Valid_tx held high with 0x55 then 0xAA -> second accepted right after first load, frames contiguous, 352 cycles, no TXD high gap before second start bit, two Done pulses.
REQ-031 Offer 0x11 while a frame is in flight and hold full -> Ready_tx=0, byte not taken, prior held byte sent unchanged.
REQ-032 Assert reset 1 cycle at cycle 50 of a frame -> TXD=1, Busy=0, Ready_tx=1 next cycle, no Done; next byte frames correctly.
REQ-033 PARITY_EN=0, CLKS_PER_BIT=4, send 0xFF -> 40-cycle frame, start, eight 1s, stop.

Source files
------------

// File: rtl/transmitter_ash_if.sv
// -----------------------------------------------------------------------------
// transmitter_ash_if
//   Byte handshake between a producer and the transmitter_ash serialiser.
//
//   TX_Data  : byte offered by the producer (sampled only on accept)
//   Valid_tx : producer has a byte on TX_Data
//   Ready_tx : transmitter holding register is empty
//
//   A byte moves on any posedge where Valid_tx and Ready_tx are both high.
//   master = producer side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface transmitter_ash_if;
    logic [7:0] TX_Data;
    logic       Valid_tx;
    logic       Ready_tx;

    modport master (
        output TX_Data,
        output Valid_tx,
        input  Ready_tx
    );

    modport slave (
        input  TX_Data,
        input  Valid_tx,
        output Ready_tx
    );
endinterface

// File: rtl/transmitter_ash.sv
// -----------------------------------------------------------------------------
// transmitter_ash
//   UART-style serial transmitter with a one-entry holding register.
//   Frame: start bit (0), 8 data bits LSB first, optional parity bit,
//   stop bit (1). Every bit lasts CLKS_PER_BIT clock cycles.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per serial bit, 2..256
//   PARITY_EN    : 1 = parity bit included in the frame, 0 = omitted
//   PARITY_ODD   : 0 = even parity, 1 = odd parity
//
// Ports
//   clk    : single clock, everything on posedge
//   reset  : synchronous, active-high
//   bus    : byte handshake (TX_Data / Valid_tx / Ready_tx), slave side
//   TXD    : registered serial line, idles high
//   Busy   : high whenever a frame is in progress (FSM not IDLE)
//   Done   : one-cycle pulse during the last cycle of each stop bit
// -----------------------------------------------------------------------------
module transmitter_ash #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                clk,
    input  logic                reset,
    transmitter_ash_if.slave    bus,
    output logic                TXD,
    output logic                Busy,
    output logic                Done
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic           PAR_ON   = (PARITY_EN != 0);
    localparam logic           ODD_BIT  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic           par_q;
    logic [7:0]     hold_q;
    logic           hold_full_q;
    logic           txd_q;
    logic           done_q;

    logic           accept;
    logic           bit_end;
    logic           load_go;

    assign bus.Ready_tx = !hold_full_q;
    assign accept       = bus.Valid_tx && !hold_full_q;
    assign bit_end      = (cnt_q == CNT_LAST);

    // A held byte is launched from IDLE, or straight out of the final stop
    // cycle so back-to-back frames have no idle gap between them.
    assign load_go = hold_full_q &&
                     ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (accept) begin
                hold_q      <= bus.TX_Data;
                hold_full_q <= 1'b1;
            end

            // TXD is registered: each transition writes the level of the
            // bit that the next cycle belongs to.
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    cnt_q <= '0;
                end

                S_START: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                        txd_q     <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            if (PAR_ON) begin
                                state_q <= S_PARITY;
                                txd_q   <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= S_STOP;
                        txd_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        txd_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // Registered pulse lands on the final stop cycle.
                        if (cnt_q == CNT_PRE) begin
                            done_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    txd_q   <= 1'b1;
                end
            endcase

            // Launch overrides the state-local updates above. Accept and
            // launch never coincide: accept needs hold empty, launch needs
            // it full.
            if (load_go) begin
                shift_q     <= hold_q;
                par_q       <= (^hold_q) ^ ODD_BIT;
                hold_full_q <= 1'b0;
                state_q     <= S_START;
                cnt_q       <= '0;
                txd_q       <= 1'b0;
            end
        end
    end

    assign TXD  = txd_q;
    assign Busy = (state_q != S_IDLE);
    assign Done = done_q;

endmodule

// File: tb/tb_transmitter_ash.sv
// -----------------------------------------------------------------------------
// tb_transmitter_ash
//   Three transmitter instances with different parameter sets:
//     dut0: CLKS_PER_BIT=16, parity on, even
//     dut1: CLKS_PER_BIT=4,  parity on, odd
//     dut2: CLKS_PER_BIT=4,  parity off
//   A negedge logger records every output of every instance per cycle;
//   frames are checked afterwards against hand-computed bit patterns.
//   Frame patterns are written as {stop, parity, data[7:0], start}, bit 0
//   is the first bit on the line.
// -----------------------------------------------------------------------------
module tb_transmitter_ash;

    localparam int LOGN = 8192;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data [3];
    logic [2:0] valid;
    logic [2:0] ready_w;
    logic [2:0] txd_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic txd_log   [3][LOGN];
    logic busy_log  [3][LOGN];
    logic done_log  [3][LOGN];
    logic ready_log [3][LOGN];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            transmitter_ash_if bus ();
            assign bus.TX_Data  = tx_data[gi];
            assign bus.Valid_tx = valid[gi];
            assign ready_w[gi]  = bus.Ready_tx;

            transmitter_ash #(
                .CLKS_PER_BIT ((gi == 0) ? 16 : 4),
                .PARITY_EN    ((gi == 2) ? 0 : 1),
                .PARITY_ODD   ((gi == 1) ? 1 : 0)
            ) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus.slave),
                .TXD   (txd_w[gi]),
                .Busy  (busy_w[gi]),
                .Done  (done_w[gi])
            );
        end
    endgenerate

    // Log index n holds the outputs that follow the (n+1)-th posedge.
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            for (int d = 0; d < 3; d++) begin
                txd_log[d][cyc]   <= txd_w[d];
                busy_log[d][cyc]  <= busy_w[d];
                done_log[d][cyc]  <= done_w[d];
                ready_log[d][cyc] <= ready_w[d];
            end
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // base = log index of the cycle right after the accepting edge;
    // frame cycle k (1..len) is log index base+k.
    task automatic check_frame(input int d, input int base, input logic [10:0] frame,
                               input int nbits, input int cpb);
        int   len;
        int   bad;
        int   idx;
        int   dones;
        int   done_at;
        int   busys;
        logic act;
        len = nbits * cpb;
        for (int i = 0; i < nbits; i++) begin
            bad = 0;
            act = frame[i];
            for (int c = 0; c < cpb; c++) begin
                idx = base + 1 + i * cpb + c;
                if (txd_log[d][idx] !== frame[i]) begin
                    if (bad == 0) act = txd_log[d][idx];
                    bad++;
                end
            end
            check($sformatf("dut%0d frame bit %0d", d, i), {31'd0, act}, {31'd0, frame[i]});
        end
        dones   = 0;
        done_at = 0;
        busys   = 0;
        for (int k = 1; k <= len; k++) begin
            if (busy_log[d][base + k] === 1'b1) busys++;
            if (done_log[d][base + k] === 1'b1) begin
                dones++;
                done_at = k;
            end
        end
        check($sformatf("dut%0d done count", d), dones, 1);
        check($sformatf("dut%0d done position", d), done_at, len);
        check($sformatf("dut%0d busy cycles", d), busys, len);
    endtask

    task automatic run_vec(input int d, input logic [7:0] data, input logic [10:0] frame,
                           input int nbits, input int cpb);
        int base;
        int len;
        len = nbits * cpb;
        tx_data[d] = data;
        valid[d]   = 1'b1;
        @(posedge clk); #1;
        base     = cyc;
        valid[d] = 1'b0;
        check($sformatf("dut%0d ready after accept", d), {31'd0, ready_w[d]}, 0);
        repeat (len + 3) @(posedge clk);
        #1;
        $display("frame dut%0d data=%02h start_index=%0d", d, data, base);
        check($sformatf("dut%0d ready after load", d), {31'd0, ready_log[d][base + 1]}, 1);
        check($sformatf("dut%0d txd start latency", d), {31'd0, txd_log[d][base + 1]}, 0);
        check_frame(d, base, frame, nbits, cpb);
        check($sformatf("dut%0d busy after frame", d), {31'd0, busy_log[d][base + len + 1]}, 0);
        check($sformatf("dut%0d txd after frame", d), {31'd0, txd_log[d][base + len + 1]}, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic [10:0] frame;
        int         nbits;
        int         cpb;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int base;
        int bad;
        int dones;

        vecs[0] = '{0, 8'hA5, 11'h54A, 11, 16};
        vecs[1] = '{0, 8'h07, 11'h60E, 11, 16};
        vecs[2] = '{0, 8'h00, 11'h400, 11, 16};
        vecs[3] = '{0, 8'hFF, 11'h5FE, 11, 16};
        vecs[4] = '{0, 8'h80, 11'h700, 11, 16};
        vecs[5] = '{1, 8'h07, 11'h40E, 11, 4};
        vecs[6] = '{1, 8'hA5, 11'h74A, 11, 4};
        vecs[7] = '{2, 8'hFF, 11'h3FE, 10, 4};
        vecs[8] = '{2, 8'h00, 11'h200, 10, 4};

        reset = 1'b1;
        valid = '0;
        for (int d = 0; d < 3; d++) tx_data[d] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state of every instance
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d reset TXD", d), {31'd0, txd_w[d]}, 1);
            check($sformatf("dut%0d reset Ready_tx", d), {31'd0, ready_w[d]}, 1);
            check($sformatf("dut%0d reset Busy", d), {31'd0, busy_w[d]}, 0);
            check($sformatf("dut%0d reset Done", d), {31'd0, done_w[d]}, 0);
        end

        // Single frames from the table
        for (int v = 0; v < 9; v++) begin
            run_vec(vecs[v].dut, vecs[v].data, vecs[v].frame, vecs[v].nbits, vecs[v].cpb);
        end

        // Back-to-back: Valid_tx held with 0x55 then 0xAA
        tx_data[0] = 8'h55;
        valid[0]   = 1'b1;
        @(posedge clk); #1;
        base       = cyc;
        tx_data[0] = 8'hAA;
        check("b2b ready after first accept", {31'd0, ready_w[0]}, 0);
        @(posedge clk); #1;
        check("b2b ready after load", {31'd0, ready_w[0]}, 1);
        @(posedge clk); #1;
        check("b2b ready after second accept", {31'd0, ready_w[0]}, 0);
        valid[0] = 1'b0;
        repeat (356) @(posedge clk);
        #1;
        $display("frame dut0 data=55,AA back-to-back start_index=%0d", base);
        check_frame(0, base, 11'h4AA, 11, 16);
        check_frame(0, base + 176, 11'h554, 11, 16);
        check("b2b last stop level", {31'd0, txd_log[0][base + 176]}, 1);
        check("b2b no gap before second start", {31'd0, txd_log[0][base + 177]}, 0);
        check("b2b busy after both", {31'd0, busy_log[0][base + 353]}, 0);

        // Offer while hold is full: 0x11 must be ignored
        tx_data[0] = 8'h3C;
        valid[0]   = 1'b1;
        @(posedge clk); #1;
        base       = cyc;
        tx_data[0] = 8'h81;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_data[0] = 8'h11;
        repeat (20) @(posedge clk);
        #1;
        check("hold full ready low", {31'd0, ready_w[0]}, 0);
        valid[0] = 1'b0;
        repeat (340) @(posedge clk);
        #1;
        $display("frame dut0 data=3C,81 with 0x11 offered while full start_index=%0d", base);
        check_frame(0, base, 11'h478, 11, 16);
        check_frame(0, base + 176, 11'h502, 11, 16);
        check("hold full nothing after", {31'd0, busy_log[0][base + 353]}, 0);

        // Reset mid-frame at frame cycle 50 with a byte waiting in hold
        tx_data[0] = 8'hA5;
        valid[0]   = 1'b1;
        @(posedge clk); #1;
        base     = cyc;
        valid[0] = 1'b0;
        @(posedge clk); #1;
        tx_data[0] = 8'h11;
        valid[0]   = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        check("mid-frame hold accepted", {31'd0, ready_w[0]}, 0);
        repeat (47) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset dut0 at frame cycle 50 start_index=%0d", base);
        check("abort TXD", {31'd0, txd_w[0]}, 1);
        check("abort Busy", {31'd0, busy_w[0]}, 0);
        check("abort Ready_tx", {31'd0, ready_w[0]}, 1);
        repeat (205) @(posedge clk);
        #1;
        bad   = 0;
        dones = 0;
        for (int k = 50; k <= 250; k++) begin
            if (txd_log[0][base + k] !== 1'b1) bad++;
            if (done_log[0][base + k] !== 1'b0) dones++;
        end
        check("abort TXD stays idle", bad, 0);
        check("abort no Done", dones, 0);
        run_vec(0, 8'h80, 11'h700, 11, 16);

        // Reset wins over an accept in the same cycle
        tx_data[0] = 8'h3C;
        valid[0]   = 1'b1;
        reset      = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        valid[0] = 1'b0;
        check("reset vs accept ready", {31'd0, ready_w[0]}, 1);
        repeat (3) @(posedge clk);
        #1;
        $display("reset dut0 with simultaneous offer of 3C");
        check("reset vs accept busy", {31'd0, busy_w[0]}, 0);
        check("reset vs accept txd", {31'd0, txd_w[0]}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
